oflow_score_calc_set_engine: RTL

//  Per-set scoring engine driven by the registration FSM. On each start_score_calc pulse it

---
 rtl/oflow_score_calc_set_engine.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/oflow_score_calc_set_engine.sv
// Scores all previous-frame objects against one set of current objects, keeping the min |dx|+|dy| per object.
// Latency start->done: num+6 cycles (num>0) or OBJ_PER_SET+1 (num=0); starts while busy are dropped, no backpressure.
module oflow_score_calc_set_engine #(
    parameter int  OBJ_PER_SET = 4,
    parameter int  COORD_W     = 11,
    parameter int  PREV_AW     = 6,
    parameter int  SET_W       = 5,
    localparam int SCORE_W     = COORD_W + 1,
    localparam int ID_W        = PREV_AW,
    localparam int OBJ_AW      = (OBJ_PER_SET > 1) ? $clog2(OBJ_PER_SET) : 1
) (
    input  logic                           clk,
    input  logic                           reset_N,
    input  logic                           start_score_calc,
    input  logic [SET_W-1:0]               counter_of_sets,
    input  logic [PREV_AW-1:0]             num_of_prev_objs,
    input  logic [OBJ_PER_SET*COORD_W-1:0] cur_cm_x,
    input  logic [OBJ_PER_SET*COORD_W-1:0] cur_cm_y,
    input  logic [OBJ_PER_SET-1:0]         cur_valid,
    output logic                           prev_rd_en,
    output logic [PREV_AW-1:0]             prev_rd_addr,
    input  logic [COORD_W-1:0]             prev_rd_cm_x,
    input  logic [COORD_W-1:0]             prev_rd_cm_y,
    output logic                           sb_wr_en,
    output logic [SET_W+OBJ_AW-1:0]        sb_wr_addr,
    output logic [ID_W-1:0]                sb_best_id,
    output logic [SCORE_W-1:0]             sb_best_score,
    output logic                           sb_valid,
    output logic                           done_score_calc,
    output logic                           busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [SCORE_W-1:0] NO_SCORE = '1;
    localparam logic [ID_W-1:0]    NO_ID    = '1;
    localparam logic [OBJ_AW-1:0]  LAST_OBJ = OBJ_AW'(OBJ_PER_SET - 1);

    logic [2:0]         state;
    logic [SET_W-1:0]   set_q;
    logic [PREV_AW-1:0] num_q;
    logic [PREV_AW-1:0] j_q;
    logic [PREV_AW-1:0] addr_d;
    logic               rd_en_d;
    logic [OBJ_AW-1:0]  wr_k;

    logic [SCORE_W-1:0] min_score     [OBJ_PER_SET];
    logic [SCORE_W-1:0] min_score_nxt [OBJ_PER_SET];
    logic [ID_W-1:0]    min_id        [OBJ_PER_SET];
    logic [ID_W-1:0]    min_id_nxt    [OBJ_PER_SET];
    logic [COORD_W-1:0] dx            [OBJ_PER_SET];
    logic [COORD_W-1:0] dy            [OBJ_PER_SET];
    logic [SCORE_W-1:0] cand          [OBJ_PER_SET];

    logic [OBJ_AW-1:0]  ld_k;
    logic [SET_W-1:0]   ld_set;
    logic               ld_valid;
    logic [ID_W-1:0]    ld_id;
    logic [SCORE_W-1:0] ld_score;

    assign busy            = (state != ST_IDLE);
    assign done_score_calc = (state == ST_DONE);
    assign prev_rd_en      = (state == ST_READ);
    assign prev_rd_addr    = prev_rd_en ? j_q : '0;

    // Compare stage: operates on the read data returned one cycle after the strobe.
    always_comb begin
        for (int i = 0; i < OBJ_PER_SET; i++) begin
            dx[i] = (cur_cm_x[i*COORD_W +: COORD_W] >= prev_rd_cm_x)
                  ? cur_cm_x[i*COORD_W +: COORD_W] - prev_rd_cm_x
                  : prev_rd_cm_x - cur_cm_x[i*COORD_W +: COORD_W];
            dy[i] = (cur_cm_y[i*COORD_W +: COORD_W] >= prev_rd_cm_y)
                  ? cur_cm_y[i*COORD_W +: COORD_W] - prev_rd_cm_y
                  : prev_rd_cm_y - cur_cm_y[i*COORD_W +: COORD_W];
            cand[i]          = {1'b0, dx[i]} + {1'b0, dy[i]};
            min_score_nxt[i] = min_score[i];
            min_id_nxt[i]    = min_id[i];
            if (rd_en_d && (cand[i] < min_score[i])) begin
                min_score_nxt[i] = cand[i];
                min_id_nxt[i]    = addr_d;
            end
        end
    end

    // Next score-board entry; uses the forwarded minimum so the final compare lands in entry 0.
    always_comb begin
        ld_k     = (state == ST_WRITE) ? wr_k + 1'b1 : '0;
        ld_set   = (state == ST_IDLE) ? counter_of_sets : set_q;
        ld_valid = cur_valid[ld_k];
        ld_id    = NO_ID;
        ld_score = NO_SCORE;
        if (ld_valid && (state != ST_IDLE)) begin
            ld_id    = min_id_nxt[ld_k];
            ld_score = min_score_nxt[ld_k];
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state         <= ST_IDLE;
            set_q         <= '0;
            num_q         <= '0;
            j_q           <= '0;
            addr_d        <= '0;
            rd_en_d       <= 1'b0;
            wr_k          <= '0;
            sb_wr_en      <= 1'b0;
            sb_wr_addr    <= '0;
            sb_best_id    <= '0;
            sb_best_score <= '0;
            sb_valid      <= 1'b0;
            for (int i = 0; i < OBJ_PER_SET; i++) begin
                min_score[i] <= '0;
                min_id[i]    <= '0;
            end
        end else begin
            rd_en_d <= prev_rd_en;
            addr_d  <= prev_rd_addr;
            for (int i = 0; i < OBJ_PER_SET; i++) begin
                min_score[i] <= min_score_nxt[i];
                min_id[i]    <= min_id_nxt[i];
            end
            case (state)
                ST_IDLE: begin
                    if (start_score_calc) begin
                        set_q <= counter_of_sets;
                        num_q <= num_of_prev_objs;
                        j_q   <= '0;
                        for (int i = 0; i < OBJ_PER_SET; i++) begin
                            min_score[i] <= NO_SCORE;
                            min_id[i]    <= NO_ID;
                        end
                        if (num_of_prev_objs != '0) begin
                            state <= ST_READ;
                        end else begin
                            state         <= ST_WRITE;
                            wr_k          <= '0;
                            sb_wr_en      <= 1'b1;
                            sb_wr_addr    <= {ld_set, ld_k};
                            sb_best_id    <= ld_id;
                            sb_best_score <= ld_score;
                            sb_valid      <= ld_valid;
                        end
                    end
                end
                ST_READ: begin
                    j_q <= j_q + 1'b1;
                    if (j_q == num_q - 1'b1) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state         <= ST_WRITE;
                    wr_k          <= '0;
                    sb_wr_en      <= 1'b1;
                    sb_wr_addr    <= {ld_set, ld_k};
                    sb_best_id    <= ld_id;
                    sb_best_score <= ld_score;
                    sb_valid      <= ld_valid;
                end
                ST_WRITE: begin
                    if (wr_k == LAST_OBJ) begin
                        state    <= ST_DONE;
                        sb_wr_en <= 1'b0;
                    end else begin
                        wr_k          <= wr_k + 1'b1;
                        sb_wr_addr    <= {ld_set, ld_k};
                        sb_best_id    <= ld_id;
                        sb_best_score <= ld_score;
                        sb_valid      <= ld_valid;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
